// File: rtl/line_rotator_pkg.sv
// Shared constants for the BT.656 line rotator: 525-line timing defaults,
// the per-line mode encoding and the single-subtract wrap helper.
package line_rotator_pkg;

  localparam int LR_LINE_MAX  = 1716;
  localparam int LR_ACT_START = 276;
  localparam int LR_ACT_LEN   = 1440;

  typedef enum logic {
    MODE_SCRAMBLE   = 1'b0,
    MODE_DESCRAMBLE = 1'b1
  } rot_mode_e;

  // Callers guarantee v < 2*m, so a single conditional subtract is a full modulo.
  function automatic logic [31:0] wrap_once(input logic [31:0] v, input logic [31:0] m);
    return (v >= m) ? (v - m) : v;
  endfunction

endpackage

// File: rtl/line_buffer_dp.sv
// Ping-pong line store: two LINE_MAX banks in one simple dual-port RAM,
// bank selected by the address MSB, registered read port.
module line_buffer_dp #(
  parameter int DATA_W   = 10,
  parameter int LINE_MAX = 1716,
  parameter int AW       = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [AW:0]       wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AW:0]       rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int PW = $clog2(2 * LINE_MAX);

  logic [DATA_W-1:0] mem_q [0:2*LINE_MAX-1];
  logic [DATA_W-1:0] rd_data_q;
  logic [PW-1:0]     wr_phys_s;
  logic [PW-1:0]     rd_phys_s;

  // Fold {bank, index} onto the packed 2*LINE_MAX storage.
  always_comb begin
    wr_phys_s = wr_addr_i[AW] ? (PW'(LINE_MAX) + PW'(wr_addr_i[AW-1:0])) : PW'(wr_addr_i[AW-1:0]);
    rd_phys_s = rd_addr_i[AW] ? (PW'(LINE_MAX) + PW'(rd_addr_i[AW-1:0])) : PW'(rd_addr_i[AW-1:0]);
  end

  // Storage array; contents are never reset, stored length decides validity.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_phys_s] <= wr_data_i;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_phys_s];
    end else begin
      rd_data_q <= rd_data_q;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/line_rotator_pp.sv
// Line-rotation scrambler/descrambler: each line is stored, then replayed one
// line later with its active window cyclically rotated by a per-line key.
module line_rotator_pp
  import line_rotator_pkg::*;
#(
  parameter int DATA_W    = 10,
  parameter int LINE_MAX  = LR_LINE_MAX,
  parameter int ACT_START = LR_ACT_START,
  parameter int ACT_LEN   = LR_ACT_LEN,
  parameter int KEY_W     = 8,
  parameter int CUT_STEP  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              H,
  input  logic              V,
  input  logic              mode,
  input  logic [KEY_W-1:0]  key,
  input  logic              key_valid,
  output logic              key_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              key_underflow,
  output logic              line_overflow
);

  localparam int AW    = $clog2(LINE_MAX + 1);
  localparam int CUT_W = $clog2(ACT_LEN) + 1;
  localparam logic [AW-1:0] LINE_MAX_A  = AW'(LINE_MAX);
  localparam logic [AW-1:0] ACT_START_A = AW'(ACT_START);
  localparam logic [AW-1:0] ACT_END_A   = AW'(ACT_START + ACT_LEN);

  logic             h_q, h_d;
  logic             wr_act_q, wr_act_d;
  logic             wr_bank_q, wr_bank_d;
  logic [AW-1:0]    wr_idx_q, wr_idx_d;
  logic [CUT_W-1:0] wr_cut_q, wr_cut_d;
  rot_mode_e        wr_mode_q, wr_mode_d;
  logic [AW-1:0]    rd_len_q, rd_len_d;
  logic [CUT_W-1:0] rd_cut_q, rd_cut_d;
  rot_mode_e        rd_mode_q, rd_mode_d;
  logic             kuf_q, kuf_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  logic             h_rise_s, wr_bank_s, wr_en_s, rd_en_s;
  logic [AW-1:0]    pos_s, fin_len_s, cur_len_s, rd_idx_s;
  logic [CUT_W-1:0] fin_cut_s, key_cut_s, line_cut_s, cur_cut_s;
  rot_mode_e        cur_mode_s;
  logic [31:0]      key_prod_s, win_ofs_s, rot_ofs_s;

  // Line timing, key decode and the rotated read address for this position.
  always_comb begin
    h_rise_s   = H & ~h_q;
    pos_s      = h_rise_s ? '0 : wr_idx_q;
    wr_bank_s  = h_rise_s ? ~wr_bank_q : wr_bank_q;
    fin_len_s  = wr_act_q ? wr_idx_q : '0;
    // A truncated line cannot be rotated without reading unwritten samples.
    fin_cut_s  = (fin_len_s < ACT_END_A) ? '0 : wr_cut_q;
    key_prod_s = 32'(key) * 32'(CUT_STEP);
    key_cut_s  = CUT_W'(wrap_once(key_prod_s, 32'(ACT_LEN)));
    line_cut_s = (~V & key_valid) ? key_cut_s : '0;
    cur_len_s  = h_rise_s ? fin_len_s : rd_len_q;
    cur_cut_s  = h_rise_s ? fin_cut_s : rd_cut_q;
    cur_mode_s = h_rise_s ? wr_mode_q : rd_mode_q;
    win_ofs_s  = 32'(pos_s) - 32'(ACT_START);
    if ((pos_s >= ACT_START_A) && (pos_s < ACT_END_A)) begin
      if (cur_mode_s == MODE_DESCRAMBLE) begin
        rot_ofs_s = wrap_once(win_ofs_s + 32'(ACT_LEN) - 32'(cur_cut_s), 32'(ACT_LEN));
      end else begin
        rot_ofs_s = wrap_once(win_ofs_s + 32'(cur_cut_s), 32'(ACT_LEN));
      end
      rd_idx_s = AW'(32'(ACT_START) + rot_ofs_s);
    end else begin
      rot_ofs_s = '0;
      rd_idx_s  = pos_s;
    end
    wr_en_s = (h_rise_s | wr_act_q) & (pos_s < LINE_MAX_A);
    rd_en_s = (pos_s < LINE_MAX_A);
  end

  // Next-state: swap roles and hand line parameters over at each H rise.
  always_comb begin
    h_d       = H;
    wr_act_d  = wr_act_q;
    wr_bank_d = wr_bank_q;
    wr_idx_d  = wr_idx_q;
    wr_cut_d  = wr_cut_q;
    wr_mode_d = wr_mode_q;
    rd_len_d  = rd_len_q;
    rd_cut_d  = rd_cut_q;
    rd_mode_d = rd_mode_q;
    kuf_d     = kuf_q;
    ovf_d     = ovf_q;
    valid_d   = (pos_s < cur_len_s);
    if (h_rise_s) begin
      wr_act_d  = 1'b1;
      wr_bank_d = ~wr_bank_q;
      wr_idx_d  = AW'(1);
      wr_cut_d  = line_cut_s;
      wr_mode_d = rot_mode_e'(mode);
      rd_len_d  = fin_len_s;
      rd_cut_d  = fin_cut_s;
      rd_mode_d = wr_mode_q;
      kuf_d     = kuf_q | (~V & ~key_valid);
    end else if (wr_act_q && (wr_idx_q != LINE_MAX_A)) begin
      wr_idx_d = wr_idx_q + AW'(1);
    end else begin
      ovf_d = ovf_q | wr_act_q;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q       <= 1'b0;
      wr_act_q  <= 1'b0;
      wr_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      wr_cut_q  <= '0;
      wr_mode_q <= MODE_SCRAMBLE;
      rd_len_q  <= '0;
      rd_cut_q  <= '0;
      rd_mode_q <= MODE_SCRAMBLE;
      kuf_q     <= 1'b0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      h_q       <= h_d;
      wr_act_q  <= wr_act_d;
      wr_bank_q <= wr_bank_d;
      wr_idx_q  <= wr_idx_d;
      wr_cut_q  <= wr_cut_d;
      wr_mode_q <= wr_mode_d;
      rd_len_q  <= rd_len_d;
      rd_cut_q  <= rd_cut_d;
      rd_mode_q <= rd_mode_d;
      kuf_q     <= kuf_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
    end
  end

  line_buffer_dp #(
    .DATA_W   (DATA_W),
    .LINE_MAX (LINE_MAX),
    .AW       (AW)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_en_s),
    .wr_addr_i ({wr_bank_s, pos_s}),
    .wr_data_i (data_in),
    .rd_en_i   (rd_en_s),
    .rd_addr_i ({~wr_bank_s, rd_idx_s}),
    .rd_data_o (data_out)
  );

  assign key_ready      = h_rise_s & ~V;
  assign data_out_valid = valid_q;
  assign key_underflow  = kuf_q;
  assign line_overflow  = ovf_q;

endmodule

// File: tb/tb_line_rotator_pp.sv
// Randomized bench for line_rotator_pp: a line-level reference model plus a
// scramble->descramble chain that must reproduce its input two lines later.
module tb_line_rotator_pp;

  localparam int DW = 10, LMAX = 1716, AS = 276, AL = 1440, KW = 8, STEP = 4;
  localparam int AE = AS + AL;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, H, V, mode, key_valid;
  logic [DW-1:0] data_in, data_out;
  logic [KW-1:0] key;
  logic          key_ready, data_out_valid, key_underflow, line_overflow;

  logic          crst, c_h1, c_h2;
  logic [DW-1:0] c_din, c_mid, c_dout;
  logic [KW-1:0] c_key1, c_key2;
  logic          c_kr1, c_kr2, c_v1, c_v2, c_uf1, c_uf2, c_of1, c_of2;

  line_rotator_pp u_dut (
    .clk(clk), .reset(reset), .data_in(data_in), .H(H), .V(V), .mode(mode),
    .key(key), .key_valid(key_valid), .key_ready(key_ready),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .key_underflow(key_underflow), .line_overflow(line_overflow));

  line_rotator_pp u_scr (
    .clk(clk), .reset(crst), .data_in(c_din), .H(c_h1), .V(1'b0), .mode(1'b0),
    .key(c_key1), .key_valid(1'b1), .key_ready(c_kr1),
    .data_out(c_mid), .data_out_valid(c_v1),
    .key_underflow(c_uf1), .line_overflow(c_of1));

  line_rotator_pp u_dsc (
    .clk(clk), .reset(crst), .data_in(c_mid), .H(c_h2), .V(1'b0), .mode(1'b1),
    .key(c_key2), .key_valid(1'b1), .key_ready(c_kr2),
    .data_out(c_dout), .data_out_valid(c_v2),
    .key_underflow(c_uf2), .line_overflow(c_of2));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
  endtask

  // Reference model: whole lines kept as arrays, replayed one line later.
  logic [DW-1:0] cur_buf [LMAX];
  logic [DW-1:0] prv_buf [LMAX];
  int  cur_cnt = 0, cur_cut = 0, prv_len = 0, prv_cut = 0, pos = 0, line_no = 0;
  bit  cur_act = 0, cur_mode = 0, prv_mode = 0, h_prev = 0, m_uf = 0, m_of = 0;

  function automatic int src_of(input int p, input int c, input bit md);
    int j;
    if (p < AS || p >= AE) return p;
    j = p - AS;
    if (md) return AS + ((j - c + AL) % AL);
    return AS + ((j + c) % AL);
  endfunction

  // Directed expectations for ramp lines (-1 = no directed check here).
  function automatic int dir_exp(input int ln, input int i);
    if (ln == 1 && i == 100)  return 100;
    if (ln == 1 && i == 1715) return 691;
    if (ln == 2 && i == 275)  return 275;
    if (ln == 2 && i == 276)  return 316;
    if (ln == 2 && i == 1676) return 276;
    if (ln == 2 && i == 1715) return 315;
    return -1;
  endfunction

  task automatic step(input logic [DW-1:0] d, input bit h, input bit v, input bit md,
                      input bit kv, input int k, input bit rst);
    bit rise, exp_v;
    logic [DW-1:0] exp_d;
    data_in = d; H = h; V = v; mode = md; key_valid = kv; key = KW'(k); reset = rst;
    rise = h && !h_prev;
    #1;
    check_val("key_ready", {31'd0, key_ready}, {31'd0, rise && !v});
    if (rst) begin
      cur_act = 0; cur_cnt = 0; cur_cut = 0; cur_mode = 0;
      prv_len = 0; pos = 0; h_prev = 0; m_uf = 0; m_of = 0;
      exp_v = 0; exp_d = '0;
    end else begin
      if (rise) begin
        prv_len  = cur_act ? ((cur_cnt < LMAX) ? cur_cnt : LMAX) : 0;
        prv_cut  = (prv_len < AE) ? 0 : cur_cut;
        prv_mode = cur_mode;
        for (int i = 0; i < LMAX; i++) prv_buf[i] = cur_buf[i];
        cur_act  = 1; cur_cnt = 0; cur_mode = md;
        cur_cut  = (v || !kv) ? 0 : (k * STEP) % AL;
        if (!v && !kv) m_uf = 1;
        pos = 0;
      end else begin
        pos++;
      end
      exp_v = (pos < prv_len);
      exp_d = exp_v ? prv_buf[src_of(pos, prv_cut, prv_mode)] : '0;
      if (cur_act) begin
        if (cur_cnt < LMAX) cur_buf[cur_cnt] = d;
        else m_of = 1;
        cur_cnt++;
      end
      h_prev = h;
    end
    @(posedge clk); #1;
    check_val("valid", {31'd0, data_out_valid}, {31'd0, exp_v});
    if (exp_v || rst) check_val("data", {22'd0, data_out}, {22'd0, exp_d});
    if (rise || rst) begin
      check_val("key_underflow", {31'd0, key_underflow}, {31'd0, m_uf});
      check_val("line_overflow", {31'd0, line_overflow}, {31'd0, m_of});
    end
  endtask

  task automatic run_line(input int len, input bit v, input bit kv, input int k, input bit md,
                          input bit ramp, input int rst_at, output int vcnt);
    int de;
    vcnt = 0;
    for (int i = 0; i < len; i++) begin
      step(ramp ? DW'(i % 1024) : DW'($urandom), i < 8, v, md, kv, k, i == rst_at);
      vcnt += int'(data_out_valid);
      de = dir_exp(line_no, i);
      if (de >= 0) check_val("ramp_pos", {22'd0, data_out}, de);
    end
    line_no++;
  endtask

  int vc, t;
  int keys [8];
  logic [DW-1:0] hist [$];

  initial begin
    reset = 1'b1; H = 1'b0; V = 1'b0; mode = 1'b0; key = '0; key_valid = 1'b0; data_in = '0;
    crst = 1'b1; c_h1 = 1'b0; c_h2 = 1'b0; c_din = '0; c_key1 = '0; c_key2 = '0;
    step('0, 0, 0, 0, 0, 0, 1);
    step('0, 0, 0, 0, 0, 0, 1);
    check_val("reset_key_ready", {31'd0, key_ready}, 32'd0);

    run_line(LMAX, 0, 1, 0,  0, 1, -1, vc);  check_val("vcnt_first", vc, 32'd0);
    run_line(LMAX, 0, 1, 10, 0, 1, -1, vc);  check_val("vcnt_full", vc, 32'd1716);
    run_line(LMAX, 0, 1, $urandom_range(0, 255), 1, 0, -1, vc);
    run_line(LMAX, 1, 1, $urandom_range(0, 255), 0, 0, -1, vc);
    run_line(LMAX, 0, 0, $urandom_range(0, 255), 0, 0, -1, vc);
    check_val("underflow_sticky", {31'd0, key_underflow}, 32'd1);
    run_line(1800, 0, 1, $urandom_range(0, 255), 0, 0, -1, vc);
    run_line(LMAX, 0, 1, $urandom_range(0, 255), 1, 0, -1, vc);  check_val("vcnt_ovf", vc, 32'd1716);
    run_line(1000, 0, 1, $urandom_range(0, 255), 0, 0, -1, vc);
    run_line(LMAX, 0, 1, $urandom_range(0, 255), 0, 0, -1, vc);  check_val("vcnt_short", vc, 32'd1000);
    run_line(LMAX, 0, 1, $urandom_range(0, 255), 0, 0, 900, vc); check_val("vcnt_rst", vc, 32'd900);
    run_line(LMAX, 0, 1, $urandom_range(0, 255), 1, 0, -1, vc);  check_val("vcnt_after_rst", vc, 32'd0);
    run_line(LMAX, 0, 1, $urandom_range(0, 255), 0, 0, -1, vc);  check_val("vcnt_resume", vc, 32'd1716);
    run_line(LMAX, 0, 1, $urandom_range(0, 255), 1, 0, -1, vc);

    // Chained scramble/descramble with random per-line keys.
    H = 1'b0;
    @(posedge clk); #1;
    crst = 1'b0;
    for (int m = 0; m < 8; m++) keys[m] = $urandom_range(0, 255);
    t = 0;
    for (int m = 0; m < 8; m++) begin
      for (int k = 0; k < LMAX; k++) begin
        c_din  = DW'($urandom);
        hist.push_back(c_din);
        c_h1   = (k < 8);
        c_key1 = KW'(keys[m]);
        c_h2   = (k >= 1 && k <= 8);
        c_key2 = (m > 0) ? KW'(keys[m-1]) : '0;
        @(posedge clk); #1;
        if (t >= 2 * LMAX + 1) begin
          check_val("chain_valid", {31'd0, c_v2}, 32'd1);
          check_val("chain_data", {22'd0, c_dout}, {22'd0, hist[t - 1 - 2 * LMAX]});
        end
        t++;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
